sevseg_scan_sequencer: RTL and testbench

//  Time-multiplexes the 4-digit seven-segment display from the SevSeg peripheral register bank
//  (regBank[0] = digits 1:0, regBank[1] = digits 3:2, regBank[2] = dots).

---
 rtl/sevseg_pkg.sv | 15 +
 rtl/sevseg_hex_decoder.sv | 30 +++
 rtl/sevseg_scan_sequencer.sv | 160 ++++++++++++++++
 tb/tb_sevseg_scan_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - shared types and constants for the seven-segment scan sequencer
package sevseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_BLANK = 2'd2,
    ST_DRIVE = 2'd3
  } state_t;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [3:0] SEL_NONE   = 4'hF;
  localparam int         NUM_DIGITS = 4;

endpackage

// File: rtl/sevseg_hex_decoder.sv
// rtl/sevseg_hex_decoder.sv - combinational hex nibble to active-low {g,f,e,d,c,b,a} segments
module sevseg_hex_decoder (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_hex)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/sevseg_scan_sequencer.sv
// rtl/sevseg_scan_sequencer.sv - 4-digit seven-segment scan: per-frame snapshot, blank then drive each digit
// Optional PWM dimming via BRIGHTNESS when SEVSEG_DIM_EN is defined.
module sevseg_scan_sequencer
  import sevseg_pkg::*;
#(
  parameter int DIGIT_PERIOD = 100000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic [7:0] DIGITS_LO,
  input  logic [7:0] DIGITS_HI,
  input  logic [3:0] DOTS,
`ifdef SEVSEG_DIM_EN
  input  logic [3:0] BRIGHTNESS,
`endif
  output logic [3:0] SEG_SELECT,
  output logic [7:0] DEC_OUT,
  output logic       FRAME_DONE
);

  localparam int TW = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
  localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] DRIVE_LOAD = TW'(DIGIT_PERIOD - BLANK_CYCLES - 1);
  localparam logic [1:0]    LAST_IDX   = 2'(NUM_DIGITS - 1);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIGIT_PERIOD) begin : g_bad_params
    $error("sevseg_scan_sequencer: need 1 <= BLANK_CYCLES < DIGIT_PERIOD");
  end

  state_t          r_state, w_state_next;
  logic [1:0]      r_idx, w_idx_next;
  logic [TW-1:0]   r_timer, w_timer_next;
  logic [15:0]     r_digits;
  logic [3:0]      r_dots;
  logic [3:0]      r_sel, w_sel_next;
  logic [7:0]      r_dec, w_dec_next;
  logic            r_done, w_done_next;
  logic            w_load_shadow;
  logic [3:0]      w_nibble;
  logic [6:0]      w_seg;

`ifdef SEVSEG_DIM_EN
  logic [3:0]      r_bright;
  logic [3:0]      r_pwm, w_pwm_next;

  assign w_pwm_next = (r_state == ST_DRIVE) ? r_pwm + 4'd1 : 4'd0;
`endif

  assign w_nibble = r_digits[{r_idx, 2'b00} +: 4];

  sevseg_hex_decoder u_decoder (
    .i_hex (w_nibble),
    .o_seg (w_seg)
  );

  // Timer holds remaining cycles minus one; reloaded whenever a timed state is entered.
  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_timer_next  = r_timer;
    w_done_next   = 1'b0;
    w_load_shadow = 1'b0;
    if (!EN) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_next = ST_LOAD;
        ST_LOAD: begin
          w_state_next  = ST_BLANK;
          w_timer_next  = BLANK_LOAD;
          w_idx_next    = 2'd0;
          w_load_shadow = 1'b1;
        end
        ST_BLANK: begin
          if (r_timer == '0) begin
            w_state_next = ST_DRIVE;
            w_timer_next = DRIVE_LOAD;
          end else begin
            w_timer_next = r_timer - 1'b1;
          end
        end
        ST_DRIVE: begin
          if (r_timer == '0) begin
            w_timer_next = BLANK_LOAD;
            if (r_idx == LAST_IDX) begin
              w_state_next = ST_LOAD;
              w_done_next  = 1'b1;
            end else begin
              w_state_next = ST_BLANK;
              w_idx_next   = r_idx + 2'd1;
            end
          end else begin
            w_timer_next = r_timer - 1'b1;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs are computed from the state being entered so the pins line up with the state register.
  always_comb begin
    w_sel_next = SEL_NONE;
    w_dec_next = SEG_BLANK;
    if (w_state_next == ST_DRIVE) begin
      w_sel_next = ~(4'b0001 << r_idx);
      w_dec_next = {~r_dots[r_idx], w_seg};
`ifdef SEVSEG_DIM_EN
      if (w_pwm_next > r_bright) begin
        w_dec_next = SEG_BLANK;
      end
`endif
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= ST_IDLE;
      r_idx    <= 2'd0;
      r_timer  <= '0;
      r_digits <= 16'h0000;
      r_dots   <= 4'h0;
      r_sel    <= SEL_NONE;
      r_dec    <= SEG_BLANK;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_timer <= w_timer_next;
      r_sel   <= w_sel_next;
      r_dec   <= w_dec_next;
      r_done  <= w_done_next;
      if (w_load_shadow) begin
        r_digits <= {DIGITS_HI, DIGITS_LO};
        r_dots   <= DOTS;
      end
    end
  end

`ifdef SEVSEG_DIM_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_bright <= 4'h0;
      r_pwm    <= 4'h0;
    end else begin
      r_pwm <= w_pwm_next;
      if (w_load_shadow) begin
        r_bright <= BRIGHTNESS;
      end
    end
  end
`endif

  assign SEG_SELECT = r_sel;
  assign DEC_OUT    = r_dec;
  assign FRAME_DONE = r_done;

endmodule

// File: tb/tb_sevseg_scan_sequencer.sv
// tb/tb_sevseg_scan_sequencer.sv - self-checking bench: frame-position model plus directed literal checks and random stimulus
module tb_sevseg_scan_sequencer;

  localparam int DP    = 20;
  localparam int BC    = 4;
  localparam int FRAME = 1 + 4 * DP;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       EN;
  logic [7:0] DIGITS_LO;
  logic [7:0] DIGITS_HI;
  logic [3:0] DOTS;
  logic [3:0] SEG_SELECT;
  logic [7:0] DEC_OUT;
  logic       FRAME_DONE;
`ifdef SEVSEG_DIM_EN
  logic [3:0] BRIGHTNESS = 4'hF;
`endif

  int n_vec = 0;
  int n_err = 0;

  sevseg_scan_sequencer #(.DIGIT_PERIOD(DP), .BLANK_CYCLES(BC)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .EN         (EN),
    .DIGITS_LO  (DIGITS_LO),
    .DIGITS_HI  (DIGITS_HI),
    .DOTS       (DOTS),
`ifdef SEVSEG_DIM_EN
    .BRIGHTNESS (BRIGHTNESS),
`endif
    .SEG_SELECT (SEG_SELECT),
    .DEC_OUT    (DEC_OUT),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
  end

  // Model: position within the current frame (0 = LOAD cycle) plus the snapshot taken leaving LOAD.
  bit         m_active = 0;
  int         m_pos = 0;
  bit         m_done = 0;
  logic [15:0] m_digits = 16'h0;
  logic [3:0]  m_dots = 4'h0;
  logic [3:0]  m_bright = 4'hF;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_active = 0;
      m_pos    = 0;
      m_done   = 0;
      m_digits = 16'h0;
      m_dots   = 4'h0;
    end else if (!EN) begin
      m_active = 0;
      m_done   = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_pos    = 0;
      m_done   = 0;
    end else begin
      if (m_pos == 0) begin
        m_digits = {DIGITS_HI, DIGITS_LO};
        m_dots   = DOTS;
`ifdef SEVSEG_DIM_EN
        m_bright = BRIGHTNESS;
`endif
      end
      if (m_pos == FRAME - 1) begin
        m_pos  = 0;
        m_done = 1;
      end else begin
        m_pos  = m_pos + 1;
        m_done = 0;
      end
    end
  end

  function automatic void model_out(output logic [3:0] s, output logic [7:0] d);
    int slot, off, nib;
    s = 4'hF;
    d = 8'hFF;
    if (m_active && m_pos > 0) begin
      slot = (m_pos - 1) / DP;
      off  = (m_pos - 1) % DP;
      if (off >= BC) begin
        nib = (m_digits >> (4 * slot)) & 15;
        s = 4'hF ^ (4'(1) << slot);
        d = {~m_dots[slot], seg_tab[nib]};
`ifdef SEVSEG_DIM_EN
        if (((off - BC) % 16) > int'(m_bright)) d = 8'hFF;
`endif
      end
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    logic [3:0] es;
    logic [7:0] ed;
    model_out(es, ed);
    chk("model_sel",  SEG_SELECT, es);
    chk("model_dec",  DEC_OUT,    ed);
    chk("model_done", FRAME_DONE, int'(m_done && m_active));
  end

  task automatic lit(input string nm, input int s, input int d, input int dn);
    chk({nm, "_sel"},  SEG_SELECT, s);
    chk({nm, "_dec"},  DEC_OUT,    d);
    chk({nm, "_done"}, FRAME_DONE, dn);
  endtask

  initial begin
    RESET = 1'b1; EN = 1'b0;
    DIGITS_LO = 8'h00; DIGITS_HI = 8'h00; DOTS = 4'h0;
    #1 RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1 lit("reset", 'hF, 'hFF, 0);
    @(negedge CLK);
    RESET = 1'b1;
    DIGITS_LO = 8'h10; DIGITS_HI = 8'h32; DOTS = 4'h0; EN = 1'b1;

    for (int k = 1; k <= 400; k++) begin
      @(posedge CLK);
      #1;
      case (k)
        1:   lit("load", 'hF, 'hFF, 0);
        5:   lit("blank_end", 'hF, 'hFF, 0);
        6:   lit("d0_first", 'hE, 'hC0, 0);
        21:  lit("d0_last", 'hE, 'hC0, 0);
        22:  lit("d1_blank", 'hF, 'hFF, 0);
        26:  lit("d1", 'hD, 'hF9, 0);
        46:  lit("d2", 'hB, 'hA4, 0);
        66:  lit("d3", 'h7, 'hB0, 0);
        81:  lit("d3_last", 'h7, 'hB0, 0);
        82:  lit("done1", 'hF, 'hFF, 1);
        83:  chk("done_pulse_len", FRAME_DONE, 0);
        110: DIGITS_LO = 8'hFF;
        112: lit("no_tear_d1", 'hD, 'hF9, 0);
        162: chk("done_early", FRAME_DONE, 0);
        163: chk("done_period81", FRAME_DONE, 1);
        168: lit("new_d0", 'hE, 'h8E, 0);
        170: begin DIGITS_LO = 8'h00; DIGITS_HI = 8'h00; DOTS = 4'b0101; end
        249: lit("dot_d0", 'hE, 'h40, 0);
        269: lit("dot_d1", 'hD, 'hC0, 0);
        289: lit("dot_d2", 'hB, 'h40, 0);
        309: lit("dot_d3", 'h7, 'hC0, 0);
        325: chk("done3", FRAME_DONE, 1);
        375: begin lit("pre_abort_d2", 'hB, 'h40, 0); EN = 1'b0; end
        376: lit("abort_blank", 'hF, 'hFF, 0);
        380: begin lit("idle", 'hF, 'hFF, 0); EN = 1'b1; end
        381: lit("reload", 'hF, 'hFF, 0);
        385: lit("reblank", 'hF, 'hFF, 0);
        386: lit("restart_d0", 'hE, 'h40, 0);
        390: begin
          lit("pre_reset", 'hE, 'h40, 0);
          RESET = 1'b0;
          #1 lit("async_reset", 'hF, 'hFF, 0);
        end
        392: RESET = 1'b1;
        default: ;
      endcase
      if (k > 376 && k < 386) chk("abort_no_done", FRAME_DONE, 0);
    end

    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if ($urandom_range(0, 5) == 0) begin
        DIGITS_LO = 8'($urandom);
        DIGITS_HI = 8'($urandom);
        DOTS      = 4'($urandom);
`ifdef SEVSEG_DIM_EN
        BRIGHTNESS = 4'($urandom);
`endif
      end
      if (EN && $urandom_range(0, 149) == 0) EN = 1'b0;
      else if (!EN && $urandom_range(0, 9) == 0) EN = 1'b1;
      if ($urandom_range(0, 699) == 0) begin
        #2 RESET = 1'b0;
        #2 RESET = 1'b1;
      end
    end

    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
